// File: rtl/pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_tree
// Purpose  : N-operand, full-precision, valid/ready pipelined adder tree.
//            It has one registered pairwise-reduction level per pipeline stage.
// Revision : 1.0
// ============================================================================
module pipelined_adder_tree #(
   parameter  int WIDTH  = 8,
   parameter  int N      = 8,
   parameter  int SIGNED = 0,
   localparam int LEVELS = (N == 1) ? 1 : $clog2(N),
   localparam int OW     = (N == 1) ? WIDTH : WIDTH + $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in [N],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OW-1:0]    sum,
   output logic             busy
);

   localparam int EXT = OW - WIDTH;

   logic              w_stall;
   logic [LEVELS-1:0] w_vld;
   logic [OW-1:0]     w_ext [N];

   // The whole pipeline freezes while the output is held, so no skid buffer is needed.
   assign w_stall  = out_valid & ~out_ready;
   assign in_ready = ~w_stall;
   assign busy     = |w_vld;

   for (genvar i = 0; i < N; i++) begin : g_ext
      if (EXT == 0) begin : g_none
         assign w_ext[i] = in[i];
      end else if (SIGNED != 0) begin : g_sign
         assign w_ext[i] = {{EXT{in[i][WIDTH-1]}}, in[i]};
      end else begin : g_zero
         assign w_ext[i] = {{EXT{1'b0}}, in[i]};
      end
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      localparam int CNT_IN  = (N + (1 << l) - 1) >> l;
      localparam int CNT_OUT = (N + (1 << (l + 1)) - 1) >> (l + 1);

      logic          r_vld;
      logic          w_src_vld;
      logic [OW-1:0] w_src [CNT_IN];
      logic [OW-1:0] w_nxt [CNT_OUT];
      logic [OW-1:0] r_data [CNT_OUT];

      if (l == 0) begin : g_first
         assign w_src_vld = in_valid;
         for (genvar k = 0; k < CNT_IN; k++) begin : g_src
            assign w_src[k] = w_ext[k];
         end
      end else begin : g_next
         assign w_src_vld = g_level[l-1].r_vld;
         for (genvar k = 0; k < CNT_IN; k++) begin : g_src
            assign w_src[k] = g_level[l-1].r_data[k];
         end
      end

      // An odd trailing element is forwarded unchanged to the next level.
      for (genvar j = 0; j < CNT_OUT; j++) begin : g_elem
         if (2 * j + 1 < CNT_IN) begin : g_add
            assign w_nxt[j] = w_src[2*j] + w_src[2*j+1];
         end else begin : g_pass
            assign w_nxt[j] = w_src[2*j];
         end
      end

      assign w_vld[l] = r_vld;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld <= 1'b0;
         end else if (!w_stall) begin
            r_vld <= w_src_vld;
         end
      end

      // Data only moves with valid, so sum stays 0 until the first result arrives.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j < CNT_OUT; j++) begin
               r_data[j] <= '0;
            end
         end else if (!w_stall && w_src_vld) begin
            for (int j = 0; j < CNT_OUT; j++) begin
               r_data[j] <= w_nxt[j];
            end
         end
      end
   end

   assign out_valid = g_level[LEVELS-1].r_vld;
   assign sum       = g_level[LEVELS-1].r_data[0];

endmodule
`default_nettype wire
